// File: rtl/aux_mailbox_pkg.sv
// Shared types and sizing helpers for the aux mailbox.
package aux_mailbox_pkg;

    typedef enum logic [1:0] {
        ST_OK       = 2'b00,
        ST_TIMEOUT  = 2'b01,
        ST_FLUSHED  = 2'b10
    } status_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RD_WAIT,
        S_WR_WAIT
    } state_e;

    function automatic int ch_w(input int channels);
        return (channels <= 1) ? 1 : $clog2(channels);
    endfunction

    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/aux_mailbox_if.sv
// Control-side request bus plus host-side per-channel streams of the mailbox.
interface aux_mailbox_if #(
    parameter int DATA_W   = 32,
    parameter int CHANNELS = 2
);
    localparam int CH_W = aux_mailbox_pkg::ch_w(CHANNELS);

    logic                         read_req;
    logic                         write_req;
    logic [CH_W-1:0]              chan;
    logic [DATA_W-1:0]            data_write;
    logic [DATA_W-1:0]            data_read;
    logic [1:0]                   status;
    logic                         busy;
    logic [CHANNELS-1:0]          flush;
    logic [CHANNELS*DATA_W-1:0]   hst_tx_data;
    logic [CHANNELS-1:0]          hst_tx_valid;
    logic [CHANNELS-1:0]          hst_tx_ready;
    logic [CHANNELS-1:0]          hst_tx_block_ready;
    logic [CHANNELS*DATA_W-1:0]   hst_rx_data;
    logic [CHANNELS-1:0]          hst_rx_valid;
    logic [CHANNELS-1:0]          hst_rx_ready;
    logic [CHANNELS-1:0]          hst_rx_block_ready;

    modport slave (
        input  read_req, write_req, chan, data_write, flush,
               hst_tx_ready, hst_rx_data, hst_rx_valid,
        output data_read, status, busy, hst_tx_data, hst_tx_valid,
               hst_tx_block_ready, hst_rx_ready, hst_rx_block_ready
    );

    modport master (
        output read_req, write_req, chan, data_write, flush,
               hst_tx_ready, hst_rx_data, hst_rx_valid,
        input  data_read, status, busy, hst_tx_data, hst_tx_valid,
               hst_tx_block_ready, hst_rx_ready, hst_rx_block_ready
    );

endinterface

// File: rtl/aux_sync_fifo.sv
// Show-ahead single-clock FIFO; clr empties it and overrides any same-cycle push/pop.
module aux_sync_fifo
    import aux_mailbox_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 1024
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        push,
    input  logic                        pop,
    input  logic                        clr,
    input  logic [DATA_W-1:0]           din,
    output logic [DATA_W-1:0]           dout,
    output logic [cnt_w(DEPTH)-1:0]     count,
    output logic                        empty,
    output logic                        full
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = cnt_w(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              do_push, do_pop;

    always_comb begin
        do_push  = push && !full && !clr;
        do_pop   = pop && !empty && !clr;
        wr_ptr_d = wr_ptr_q + AW'(do_push);
        rd_ptr_d = rd_ptr_q + AW'(do_pop);
        count_d  = count_q + CW'(do_push) - CW'(do_pop);
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset so it can map onto RAM; count gates visibility.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

    assign dout  = mem_q[rd_ptr_q];
    assign count = count_q;
    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));

endmodule

// File: rtl/aux_mailbox.sv
// Multi-channel mailbox: control FSM pops per-channel in-FIFOs and pushes out-FIFOs,
// with timeout and flush aborts; host side streams the other FIFO ends.
module aux_mailbox
    import aux_mailbox_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int CHANNELS    = 2,
    parameter int DEPTH       = 1024,
    parameter int RD_BLOCK    = 4,
    parameter int WR_BLOCK    = 512,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic        clk,
    input  logic        reset_n,
    aux_mailbox_if.slave bus
);
    localparam int CH_W = ch_w(CHANNELS);
    localparam int CW   = cnt_w(DEPTH);

    logic [CHANNELS-1:0]             in_pop, in_empty, in_full;
    logic [CHANNELS-1:0]             out_push, out_empty, out_full;
    logic [CHANNELS-1:0][DATA_W-1:0] in_head, out_head, rx_data;
    logic [CHANNELS-1:0][CW-1:0]     in_cnt, out_cnt;

    state_e            state_q;
    status_e           status_q;
    logic [CH_W-1:0]   ch_q;
    logic [DATA_W-1:0] wdata_q, data_read_q;
    logic              busy_int_q;
    logic [31:0]       timer_q;

    logic              cur_in_empty, cur_out_full, cur_flush, timeout_hit;
    logic [DATA_W-1:0] cur_in_head;

    assign rx_data = bus.hst_rx_data;

    // Channel mux by compare rather than index, so any CHANNELS value is safe.
    always_comb begin
        cur_in_empty = 1'b1;
        cur_out_full = 1'b1;
        cur_flush    = 1'b0;
        cur_in_head  = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (ch_q == CH_W'(c)) begin
                cur_in_empty = in_empty[c];
                cur_out_full = out_full[c];
                cur_flush    = bus.flush[c];
                cur_in_head  = in_head[c];
            end
        end
    end

    assign timeout_hit = (TIMEOUT_CYC != 0) && (timer_q == 32'(TIMEOUT_CYC - 1));

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        assign in_pop[g]   = (state_q == S_RD_WAIT) && (ch_q == CH_W'(g)) && !in_empty[g];
        assign out_push[g] = (state_q == S_WR_WAIT) && (ch_q == CH_W'(g)) && !out_full[g];

        aux_sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_in_fifo (
            .clk(clk), .reset_n(reset_n),
            .push(bus.hst_rx_valid[g]), .pop(in_pop[g]), .clr(bus.flush[g]),
            .din(rx_data[g]), .dout(in_head[g]), .count(in_cnt[g]),
            .empty(in_empty[g]), .full(in_full[g])
        );

        aux_sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_out_fifo (
            .clk(clk), .reset_n(reset_n),
            .push(out_push[g]), .pop(bus.hst_tx_ready[g]), .clr(bus.flush[g]),
            .din(wdata_q), .dout(out_head[g]), .count(out_cnt[g]),
            .empty(out_empty[g]), .full(out_full[g])
        );

        assign bus.hst_tx_valid[g]       = !out_empty[g];
        assign bus.hst_tx_block_ready[g] = out_cnt[g] >= CW'(RD_BLOCK);
        assign bus.hst_rx_ready[g]       = !in_full[g];
        assign bus.hst_rx_block_ready[g] = (CW'(DEPTH) - in_cnt[g]) >= CW'(WR_BLOCK);
    end

    assign bus.hst_tx_data = out_head;
    assign bus.data_read   = data_read_q;
    assign bus.status      = status_q;
    assign bus.busy        = busy_int_q | bus.read_req | bus.write_req;

    // Flush is checked before pop/push: the FIFO discards that edge's transfer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            status_q    <= ST_OK;
            ch_q        <= '0;
            wdata_q     <= '0;
            data_read_q <= '0;
            busy_int_q  <= 1'b1;
            timer_q     <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    busy_int_q <= 1'b0;
                    timer_q    <= '0;
                    if (bus.read_req) begin
                        ch_q       <= bus.chan;
                        state_q    <= S_RD_WAIT;
                        busy_int_q <= 1'b1;
                    end else if (bus.write_req) begin
                        ch_q       <= bus.chan;
                        wdata_q    <= bus.data_write;
                        state_q    <= S_WR_WAIT;
                        busy_int_q <= 1'b1;
                    end
                end
                S_RD_WAIT: begin
                    if (cur_flush || !cur_in_empty || timeout_hit) begin
                        state_q    <= S_IDLE;
                        busy_int_q <= 1'b0;
                        timer_q    <= '0;
                        if (cur_flush) begin
                            status_q    <= ST_FLUSHED;
                            data_read_q <= '0;
                        end else if (!cur_in_empty) begin
                            status_q    <= ST_OK;
                            data_read_q <= cur_in_head;
                        end else begin
                            status_q    <= ST_TIMEOUT;
                            data_read_q <= '0;
                        end
                    end else if (TIMEOUT_CYC != 0) begin
                        timer_q <= timer_q + 32'd1;
                    end
                end
                S_WR_WAIT: begin
                    if (cur_flush || !cur_out_full || timeout_hit) begin
                        state_q    <= S_IDLE;
                        busy_int_q <= 1'b0;
                        timer_q    <= '0;
                        if (cur_flush)          status_q <= ST_FLUSHED;
                        else if (!cur_out_full) status_q <= ST_OK;
                        else                    status_q <= ST_TIMEOUT;
                    end else if (TIMEOUT_CYC != 0) begin
                        timer_q <= timer_q + 32'd1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aux_mailbox.sv
// Scoreboard bench for aux_mailbox: small DEPTH and TIMEOUT so stall and abort paths are reachable.
module tb_aux_mailbox;
    localparam int DW = 32;
    localparam int CH = 2;
    localparam int DEPTH = 8;

    typedef struct {
        logic [DW-1:0] data;
        logic [1:0]    st;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_chk = 0;
    int   n_err = 0;

    exp_t          exp_q[$];
    logic [DW-1:0] in_q [CH][$];
    logic [DW-1:0] out_q[CH][$];
    logic [DW-1:0] last_data = '0;

    aux_mailbox_if #(.DATA_W(DW), .CHANNELS(CH)) bus ();

    aux_mailbox #(
        .DATA_W(DW), .CHANNELS(CH), .DEPTH(DEPTH),
        .RD_BLOCK(4), .WR_BLOCK(4), .TIMEOUT_CYC(16)
    ) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void exp_rd(input int ch);
        exp_t e;
        if (in_q[ch].size() > 0) begin
            e.data = in_q[ch].pop_front();
            e.st   = 2'b00;
        end else begin
            e.data = '0;
            e.st   = 2'b01;
        end
        last_data = e.data;
        exp_q.push_back(e);
    endfunction

    function automatic void exp_wr(input int ch, input logic [DW-1:0] d);
        exp_t e;
        out_q[ch].push_back(d);
        e.data = last_data;
        e.st   = 2'b00;
        exp_q.push_back(e);
    endfunction

    // Issue one control request, wait for busy to fall, then score the result.
    task automatic op(input bit rd, input bit wr, input int ch, input logic [DW-1:0] wd, input int exp_cyc);
        int   cyc;
        bit   done;
        exp_t e;
        @(posedge clk); #1;
        bus.read_req = rd; bus.write_req = wr; bus.chan = 1'(ch); bus.data_write = wd;
        @(negedge clk);
        cyc = bus.busy ? 1 : 0;
        @(posedge clk); #1;
        bus.read_req = 1'b0; bus.write_req = 1'b0;
        done = 1'b0;
        for (int k = 0; k < 100 && !done; k++) begin
            @(negedge clk);
            if (!bus.busy) done = 1'b1;
            else cyc++;
        end
        chk("op_done", done, 1'b1);
        if (exp_q.size() > 0) e = exp_q.pop_front();
        else begin e.data = 'x; e.st = 'x; end
        if (exp_cyc > 0) chk("busy_cycles", cyc, exp_cyc);
        chk("data_read", bus.data_read, e.data);
        chk("status", bus.status, e.st);
    endtask

    task automatic host_push(input int ch, input logic [DW-1:0] d);
        @(posedge clk); #1;
        bus.hst_rx_valid[ch] = 1'b1;
        bus.hst_rx_data[ch*DW +: DW] = d;
        @(posedge clk); #1;
        bus.hst_rx_valid[ch] = 1'b0;
        in_q[ch].push_back(d);
    endtask

    task automatic host_pop(input int ch);
        logic [DW-1:0] e;
        @(posedge clk); #1;
        chk("tx_valid_pop", bus.hst_tx_valid[ch], 1'b1);
        bus.hst_tx_ready[ch] = 1'b1;
        @(negedge clk);
        e = (out_q[ch].size() > 0) ? out_q[ch].pop_front() : 'x;
        chk("tx_data", bus.hst_tx_data[ch*DW +: DW], e);
        @(posedge clk); #1;
        bus.hst_tx_ready[ch] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.read_req = 0; bus.write_req = 0; bus.chan = '0; bus.data_write = '0;
        bus.flush = '0; bus.hst_tx_ready = '0; bus.hst_rx_valid = '0; bus.hst_rx_data = '0;

        // reset state
        repeat (2) @(negedge clk);
        chk("rst_busy", bus.busy, 1'b1);
        chk("rst_status", bus.status, 2'b00);
        chk("rst_data", bus.data_read, 32'h0);
        chk("rst_tx_valid", bus.hst_tx_valid, 2'b00);
        chk("rst_rx_ready", bus.hst_rx_ready, 2'b11);
        chk("rst_rx_blk", bus.hst_rx_block_ready, 2'b11);
        chk("rst_tx_blk", bus.hst_tx_block_ready, 2'b00);
        reset_n = 1'b1;
        #1 chk("rel_busy_hold", bus.busy, 1'b1);
        @(negedge clk);
        chk("rel_busy_clear", bus.busy, 1'b0);

        // 1: control writes stream out on ch1
        exp_wr(1, 32'hDEADBEEF); op(0, 1, 1, 32'hDEADBEEF, 2);
        chk("t1_valid1", bus.hst_tx_valid[1], 1'b1);
        chk("t1_blk_early", bus.hst_tx_block_ready[1], 1'b0);
        for (int i = 1; i <= 3; i++) begin exp_wr(1, 32'(i)); op(0, 1, 1, 32'(i), 2); end
        chk("t1_blk", bus.hst_tx_block_ready[1], 1'b1);
        chk("t1_ch0_untouched", bus.hst_tx_valid[0], 1'b0);
        repeat (4) host_pop(1);
        @(negedge clk);
        chk("t1_drained", bus.hst_tx_valid[1], 1'b0);

        // 2: host pushes, control reads
        host_push(0, 32'hA5); host_push(0, 32'h5A);
        @(negedge clk);
        chk("t2_rx_blk", bus.hst_rx_block_ready[0], 1'b1);
        exp_rd(0); op(1, 0, 0, '0, 2);
        exp_rd(0); op(1, 0, 0, '0, 2);

        // 3: timeouts on empty ch1, second one proves the timer restarted
        exp_rd(1); op(1, 0, 1, '0, 17);
        exp_rd(1); op(1, 0, 1, '0, 17);

        // 4: fill ch0 out-FIFO, stalled 9th write released by a host pop
        for (int i = 0; i < 8; i++) begin exp_wr(0, 32'h100 + 32'(i)); op(0, 1, 0, 32'h100 + 32'(i), 2); end
        chk("t4_valid", bus.hst_tx_valid[0], 1'b1);
        chk("t4_blk", bus.hst_tx_block_ready[0], 1'b1);
        exp_wr(0, 32'h1FF);
        fork
            op(0, 1, 0, 32'h1FF, 7);
            begin repeat (5) @(posedge clk); host_pop(0); end
        join
        repeat (8) host_pop(0);
        @(negedge clk);
        chk("t4_drained", bus.hst_tx_valid[0], 1'b0);

        // 5: flush aborts a pending read on ch0, ch1 unaffected
        host_push(1, 32'h77);
        exp_wr(0, 32'h99); op(0, 1, 0, 32'h99, 2);
        begin
            exp_t e;
            e.data = '0; e.st = 2'b10;
            exp_q.push_back(e);
            last_data = '0;
        end
        fork
            op(1, 0, 0, '0, 4);
            begin repeat (4) @(posedge clk); #1 bus.flush = 2'b01; @(posedge clk); #1 bus.flush = 2'b00; end
        join
        out_q[0].delete(); in_q[0].delete();
        chk("t5_ch0_out_empty", bus.hst_tx_valid[0], 1'b0);
        exp_rd(1); op(1, 0, 1, '0, 2);

        // 6: read beats simultaneous write; then reset during WR_WAIT
        host_push(1, 32'h33);
        exp_rd(1); op(1, 1, 1, 32'hBAD, 2);
        chk("t6_out_unchanged", bus.hst_tx_valid[1], 1'b0);
        for (int i = 0; i < 8; i++) begin exp_wr(1, 32'h200 + 32'(i)); op(0, 1, 1, 32'h200 + 32'(i), 2); end
        @(posedge clk); #1;
        bus.write_req = 1'b1; bus.chan = 1'b1; bus.data_write = 32'hFEED;
        @(posedge clk); #1;
        bus.write_req = 1'b0;
        repeat (3) @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("t6_rst_busy", bus.busy, 1'b1);
        chk("t6_rst_status", bus.status, 2'b00);
        chk("t6_rst_data", bus.data_read, 32'h0);
        chk("t6_rst_tx_valid", bus.hst_tx_valid, 2'b00);
        chk("t6_rst_rx_ready", bus.hst_rx_ready, 2'b11);
        for (int c = 0; c < CH; c++) begin out_q[c].delete(); in_q[c].delete(); end
        last_data = '0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        #1 chk("t6_rel_busy", bus.busy, 1'b1);
        @(negedge clk);
        chk("t6_rel_clear", bus.busy, 1'b0);
        exp_wr(1, 32'hC0DE); op(0, 1, 1, 32'hC0DE, 2);
        host_pop(1);
        chk("t6_sb_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
